// File: rtl/bf16_pack_stream_ctrl.sv
// Streaming float32 -> bf16 (RNE) converter that packs two consecutive results
// into one 32-bit word; odd-length bursts close with the upper half padded.
module bf16_pack_stream_ctrl #(
  parameter logic [15:0] PAD_VAL = 16'h0000,
  parameter int          CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [31:0]      s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [31:0]      m_data_o,
  output logic [1:0]       m_keep_o,
  output logic             m_last_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  typedef enum logic [1:0] {IDLE, LOW, FULL} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lo_q;
  logic [31:0]        data_q;
  logic [1:0]         keep_q;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               acc;
  logic               start;
  logic               pair;
  logic [15:0]        bf16;

  // Round-to-nearest-even; NaNs become a quiet NaN instead of rounding into Inf.
  function automatic logic [15:0] f32_to_bf16(input logic [31:0] f);
    logic [15:0] u;
    logic [15:0] l;
    logic        rnd;
    u   = f[31:16];
    l   = f[15:0];
    rnd = (l > 16'h8000) || ((l == 16'h8000) && u[0]);
    if ((f[30:23] == 8'hFF) && (f[22:0] != 23'd0))
      return {f[31], 15'h7FC0};
    return u + {15'd0, rnd};
  endfunction

  assign bf16      = f32_to_bf16(s_data_i);
  assign s_ready_o = (state_q != FULL) || m_ready_i;
  assign acc       = s_valid_i && s_ready_o;
  // A new word begins from IDLE, or from FULL when the held word drains this cycle.
  assign start     = acc && ((state_q == IDLE) || (state_q == FULL));
  assign pair      = acc && (state_q == LOW);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc) state_d = s_last_i ? FULL : LOW;
      LOW:  if (acc) state_d = FULL;
      FULL: if (m_ready_i) begin
              if (acc) state_d = s_last_i ? FULL : LOW;
              else     state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lo_q    <= 16'd0;
      data_q  <= 32'd0;
      keep_q  <= 2'b00;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start && !s_last_i)
        lo_q <= bf16;
      if (start && s_last_i) begin
        data_q <= {PAD_VAL, bf16};
        keep_q <= 2'b01;
        last_q <= 1'b1;
      end else if (pair) begin
        data_q <= {bf16, lo_q};
        keep_q <= 2'b11;
        last_q <= s_last_i;
      end
      if ((state_q == FULL) && m_ready_i)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign m_valid_o  = (state_q == FULL);
  assign m_data_o   = data_q;
  assign m_keep_o   = keep_q;
  assign m_last_o   = last_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_bf16_pack_stream_ctrl.sv
// Directed self-checking bench for bf16_pack_stream_ctrl.
module tb_bf16_pack_stream_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_data_i;
  logic        s_last_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic [1:0]  m_keep_o;
  logic        m_last_o;
  logic [15:0] word_cnt_o;

  int checks = 0;
  int errors = 0;

  bf16_pack_stream_ctrl #(.PAD_VAL(16'h0000), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_keep_o(m_keep_o), .m_last_o(m_last_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = l;
    @(negedge clk_i);
  endtask

  task automatic idle();
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [1:0] k,
                          input logic l);
    chk({tag, "_valid"}, {31'd0, m_valid_o}, 32'd1);
    chk({tag, "_data"},  m_data_o, d);
    chk({tag, "_keep"},  {30'd0, m_keep_o}, {30'd0, k});
    chk({tag, "_last"},  {31'd0, m_last_o}, {31'd0, l});
  endtask

  initial begin
    rst_ni = 1'b0; s_valid_i = 1'b0; s_data_i = 32'd0; s_last_i = 1'b0; m_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_data",  m_data_o, 32'd0);
    chk("rst_keep",  {30'd0, m_keep_o}, 32'd0);
    chk("rst_last",  {31'd0, m_last_o}, 32'd0);
    chk("rst_cnt",   {16'd0, word_cnt_o}, 32'd0);
    chk("rst_ready", {31'd0, s_ready_o}, 32'd1);

    // Simple pair
    send(32'h40490FDB, 1'b0);
    chk("pair_lowheld", {31'd0, m_valid_o}, 32'd0);
    send(32'hC0490FDB, 1'b1);
    chk_word("pair", 32'hC0494049, 2'b11, 1'b1);
    idle();
    chk("pair_drain", {31'd0, m_valid_o}, 32'd0);
    chk("pair_cnt", {16'd0, word_cnt_o}, 32'd1);

    // Rounding edges, continuous stream
    send(32'h00007FFF, 1'b0);
    send(32'h00008000, 1'b0);
    chk_word("rnd1", 32'h00000000, 2'b11, 1'b0);
    send(32'h00008001, 1'b0);
    chk("rnd_gap", {31'd0, m_valid_o}, 32'd0);
    chk("rnd_cnt1", {16'd0, word_cnt_o}, 32'd2);
    send(32'h80008001, 1'b1);
    chk_word("rnd2", 32'h80010001, 2'b11, 1'b1);
    idle();
    chk("rnd_cnt2", {16'd0, word_cnt_o}, 32'd3);

    // Overflow to Inf and odd burst end
    send(32'h7F7F7FFF, 1'b0);
    send(32'h7F7F8000, 1'b0);
    chk_word("ovf", 32'h7F807F7F, 2'b11, 1'b0);
    send(32'hFF7F8000, 1'b1);
    chk_word("odd", 32'h0000FF80, 2'b01, 1'b1);
    idle();
    chk("odd_cnt", {16'd0, word_cnt_o}, 32'd5);

    // NaN stays NaN, Inf passes
    send(32'h7F800001, 1'b0);
    send(32'h7F800000, 1'b1);
    chk_word("nan", 32'h7F807FC0, 2'b11, 1'b1);
    idle();
    chk("nan_cnt", {16'd0, word_cnt_o}, 32'd6);

    // Backpressure with an element waiting
    m_ready_i = 1'b0;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    s_data_i = 32'h40400000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'd0, s_ready_o}, 32'd0);
      chk_word("bp_hold", 32'h40003F80, 2'b11, 1'b0);
      chk("bp_cnt", {16'd0, word_cnt_o}, 32'd6);
      @(negedge clk_i);
    end
    m_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, s_ready_o}, 32'd1);
    @(negedge clk_i);
    chk("bp_cnt2", {16'd0, word_cnt_o}, 32'd7);
    chk("bp_low", {31'd0, m_valid_o}, 32'd0);
    send(32'h40800000, 1'b1);
    chk_word("bp_next", 32'h40804040, 2'b11, 1'b1);
    idle();
    chk("bp_cnt3", {16'd0, word_cnt_o}, 32'd8);

    // Async reset while LOW
    send(32'h12345678, 1'b0);
    s_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rstlow_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rstlow_cnt", {16'd0, word_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Async reset while FULL
    m_ready_i = 1'b0;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    s_valid_i = 1'b0;
    chk("rstfull_pre", {31'd0, m_valid_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstfull_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rstfull_data", m_data_o, 32'd0);
    chk("rstfull_cnt", {16'd0, word_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_ready_i = 1'b1;

    // Fresh pair after reset
    send(32'h3FC00000, 1'b0);
    send(32'hC0200000, 1'b1);
    chk_word("fresh", 32'hC0203FC0, 2'b11, 1'b1);
    idle();
    chk("fresh_cnt", {16'd0, word_cnt_o}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
